// File: rtl/prio_pkg.sv
// prio_pkg: shared constants and index-width helper for the priority encoder family
package prio_pkg;
  localparam int RR_MODE_FIXED = 0;
  localparam int RR_MODE_RR    = 1;
  // Smallest r with 2**r >= v; at least 1 so a 2-bit vector still gets a 1-bit index
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/lsb_find.sv
// lsb_find: combinational lowest-set-bit finder returning index, one-hot and any-set
module lsb_find
  import prio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        vec,
  output logic [clog2(WIDTH)-1:0] idx,
  output logic [WIDTH-1:0]        onehot,
  output logic                    any
);
  localparam int POS_W = clog2(WIDTH);
  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (vec[i]) idx = POS_W'(i);
    any = |vec;
    onehot = vec & (~vec + WIDTH'(1));
  end
endmodule

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: registered fixed/round-robin priority encoder with valid/ready handshake
module priority_encoder_rr
  import prio_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RR_MODE = RR_MODE_FIXED
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [WIDTH-1:0]        req,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [clog2(WIDTH)-1:0] pos,
  output logic [WIDTH-1:0]        grant,
  output logic                    none,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int POS_W = clog2(WIDTH);
  logic             accept;
  logic [POS_W-1:0] win_idx;
  logic [WIDTH-1:0] win_oh;
  logic             win_any;
  logic             out_valid_q, out_valid_d, none_q, none_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign pos       = pos_q;
  assign grant     = grant_q;
  assign none      = none_q;
  if (RR_MODE == RR_MODE_RR) begin : g_rr
    logic [POS_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] masked;
    logic [POS_W-1:0] m_idx, r_idx;
    logic [WIDTH-1:0] m_oh, r_oh;
    logic             m_any, r_any;
    assign masked = req & ~((WIDTH'(1) << ptr_q) - WIDTH'(1));
    lsb_find #(.WIDTH(WIDTH)) u_masked (.vec(masked), .idx(m_idx), .onehot(m_oh), .any(m_any));
    lsb_find #(.WIDTH(WIDTH)) u_raw    (.vec(req),    .idx(r_idx), .onehot(r_oh), .any(r_any));
    assign win_idx = m_any ? m_idx : r_idx;
    assign win_oh  = m_any ? m_oh : r_oh;
    assign win_any = r_any;
    // Advance past the winner on every non-empty accept, wrapping at WIDTH-1 for any WIDTH
    always_comb begin
      ptr_d = (accept && win_any) ? ((win_idx == POS_W'(WIDTH - 1)) ? '0 : win_idx + POS_W'(1)) : ptr_q;
    end
    // Round-robin pointer register
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ptr_q <= '0;
      else         ptr_q <= ptr_d;
    end
  end else begin : g_fixed
    lsb_find #(.WIDTH(WIDTH)) u_raw (.vec(req), .idx(win_idx), .onehot(win_oh), .any(win_any));
  end
  // Single-entry pipeline stage: load on accept, otherwise hold until drained
  always_comb begin
    out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    pos_d       = accept ? win_idx : pos_q;
    grant_d     = accept ? win_oh : grant_q;
    none_d      = accept ? !win_any : none_q;
  end
  // Result and valid registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      pos_q       <= '0;
      grant_q     <= '0;
      none_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      pos_q       <= pos_d;
      grant_q     <= grant_d;
      none_q      <= none_d;
    end
  end
endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr: directed checks of fixed, round-robin and non-power-of-two encoders
module tb_priority_encoder_rr;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] req_a = '0, req_b = '0, grant_a, grant_b;
  logic [4:0] req_c = '0, grant_c;
  logic [2:0] pos_a, pos_b, pos_c;
  logic vin_a = 0, vin_b = 0, vin_c = 0, ordy_a = 1, ordy_b = 1, ordy_c = 1;
  logic irdy_a, irdy_b, irdy_c, none_a, none_b, none_c, vout_a, vout_b, vout_c;

  always #5 clk = ~clk;

  priority_encoder_rr #(.WIDTH(8), .RR_MODE(0)) dut_a (
    .clk(clk), .resetn(resetn), .req(req_a), .in_valid(vin_a), .in_ready(irdy_a),
    .pos(pos_a), .grant(grant_a), .none(none_a), .out_valid(vout_a), .out_ready(ordy_a));
  priority_encoder_rr #(.WIDTH(8), .RR_MODE(1)) dut_b (
    .clk(clk), .resetn(resetn), .req(req_b), .in_valid(vin_b), .in_ready(irdy_b),
    .pos(pos_b), .grant(grant_b), .none(none_b), .out_valid(vout_b), .out_ready(ordy_b));
  priority_encoder_rr #(.WIDTH(5), .RR_MODE(1)) dut_c (
    .clk(clk), .resetn(resetn), .req(req_c), .in_valid(vin_c), .in_ready(irdy_c),
    .pos(pos_c), .grant(grant_c), .none(none_c), .out_valid(vout_c), .out_ready(ordy_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rr_b(input logic [7:0] r, input logic [2:0] exp_pos, input string tag);
    req_b = r;
    step();
    check(tag, {61'd0, pos_b}, {61'd0, exp_pos});
  endtask

  initial begin
    #2;
    check("rst_vout", vout_b, 0);
    check("rst_grant", grant_b, 0);
    check("rst_pos", pos_a, 0);
    check("rst_none", none_a, 0);
    check("rst_irdy", irdy_a, 1);
    #10 resetn = 1'b1;
    // fixed priority
    vin_a = 1; req_a = 8'b0001_0100;
    step();
    check("fix_pos", pos_a, 2);
    check("fix_grant", grant_a, 8'h04);
    check("fix_none", none_a, 0);
    check("fix_vout", vout_a, 1);
    req_a = 8'h00;
    step();
    check("fix0_pos", pos_a, 0);
    check("fix0_grant", grant_a, 0);
    check("fix0_none", none_a, 1);
    req_a = 8'hA0;
    step();
    check("fix_hi_pos", pos_a, 5);
    vin_a = 0;
    step();
    check("fix_drain", vout_a, 0);
    // round robin back-to-back
    vin_b = 1;
    rr_b(8'hFF, 0, "rr_ff0");
    rr_b(8'hFF, 1, "rr_ff1");
    rr_b(8'hFF, 2, "rr_ff2");
    rr_b(8'hFF, 3, "rr_ff3");
    rr_b(8'hFF, 4, "rr_ptr4");
    rr_b(8'h20, 5, "rr_set6");
    rr_b(8'h03, 0, "rr_wrap");
    rr_b(8'h81, 7, "rr_top");
    rr_b(8'hFF, 0, "rr_ptr0");
    req_b = 8'h00;
    step();
    check("rr0_none", none_b, 1);
    check("rr0_grant", grant_b, 0);
    check("rr0_pos", pos_b, 0);
    rr_b(8'h03, 1, "rr0_ptr_keep");
    check("rr_grant1", grant_b, 8'h02);
    // backpressure
    vin_b = 0;
    step();
    check("bp_empty", vout_b, 0);
    ordy_b = 0; vin_b = 1; req_b = 8'h10;
    step();
    check("bp_pos", pos_b, 4);
    check("bp_irdy", irdy_b, 0);
    req_b = 8'h01;
    step();
    check("bp_hold_pos", pos_b, 4);
    check("bp_hold_grant", grant_b, 8'h10);
    check("bp_hold_vout", vout_b, 1);
    req_b = 8'h21; ordy_b = 1;
    #1;
    check("bp_irdy_comb", irdy_b, 1);
    step();
    check("bp_ptr_frozen", pos_b, 5);
    check("bp_vout_stays", vout_b, 1);
    rr_b(8'h40, 6, "pre_rst");
    // asynchronous reset between edges
    #3 resetn = 1'b0;
    #1;
    check("arst_vout", vout_b, 0);
    check("arst_grant", grant_b, 0);
    req_b = 8'h81;
    #2 resetn = 1'b1;
    step();
    check("post_rst_pos", pos_b, 0);
    rr_b(8'h80, 7, "post_rst_hi");
    vin_b = 0;
    // non-power-of-two width
    vin_c = 1; req_c = 5'b01000;
    step();
    check("w5_pos3", pos_c, 3);
    req_c = 5'b10000;
    step();
    check("w5_pos4", pos_c, 4);
    check("w5_grant", grant_c, 5'b10000);
    req_c = 5'b11110;
    step();
    check("w5_wrap", pos_c, 1);
    req_c = 5'b00011;
    step();
    check("w5_next", pos_c, 0);
    vin_c = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/priority_encoder_rr.md
# priority_encoder_rr

Parametrised, registered priority encoder with an optional round-robin mode and a valid/ready handshake on both sides. It takes a WIDTH-bit request vector and returns the winning bit index, a one-hot grant and a no-request flag, one cycle later. It replaces the fixed 8-bit combinational encoder wherever request vectors are wider, fairness is needed, or the result feeds a pipelined consumer.

## Interface
- WIDTH, 8: request vector width, 2..64; need not be a power of two.
- RR_MODE, 0: 0 = fixed priority (bit 0 highest); 1 = round-robin from a rotating pointer.
- POS_W, derived = clog2(WIDTH): index width; not overridable.

- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  WIDTH  request vector, sampled on accept.
- in_valid  in  1  req is valid this cycle.
- in_ready  out  1  block can accept req this cycle.
- pos  out  POS_W  winning index.
- grant  out  WIDTH  one-hot of pos; all-zero when none=1.
- none  out  1  the accepted req was all-zero.
- out_valid  out  1  pos/grant/none hold a result.
- out_ready  in  1  consumer takes the result this cycle.

## Operation
- Accept: in_valid && in_ready. Output handshake completes on out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a single-entry pipeline register: a new result may load in the same cycle the old one drains.
- Fixed mode: winner is the lowest-indexed set bit of req.
- RR mode: pointer ptr (POS_W bits, range 0..WIDTH-1).
  - The winner is the lowest set bit with index ≥ ptr.
  - If no such bit exists, the winner is the lowest set bit overall (wrap-around).
- Pointer update, RR mode, on accept with req≠0: ptr ← pos+1, or 0 if pos = WIDTH-1. The wrap must hold for non-power-of-two WIDTH.
- req = 0 on accept: pos = 0, grant = 0, none = 1, ptr unchanged. This is the all-zero case of the old encoder made explicit.
- Fixed mode: ptr is not implemented; tie it off to 0.
- Result registers (pos, grant, none) hold their value while out_valid && !out_ready, regardless of req or in_valid.
- No state machine beyond out_valid and ptr. States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on drain with simultaneous accept, or on stall.

## Timing
- Reset values (asynchronous, active while resetn=0): out_valid=0, pos=0, grant=0, none=0, ptr=0. in_ready reads 1 during and after reset.
- Latency: exactly 1 cycle from accept to out_valid with the result for that req.
- Throughput: 1 result per cycle while out_ready stays high.
- The pointer update is registered on the same edge as the result. The next accepted req uses the updated ptr, including back-to-back accepts.
- Reset mid-operation: a pending result is discarded and ptr returns to 0. The first post-reset accept behaves as fixed priority from bit 0.
- Combinational paths:
  - out_ready → in_ready is the only input-to-output path.
  - req → outputs is fully registered.

## Structure
- Shared package prio_pkg holds the clog2 function used for POS_W, plus the constants RR_MODE_FIXED=0 and RR_MODE_RR=1.
- One sub-module, lsb_find #(WIDTH): purely combinational lowest-set-bit finder with outputs idx, onehot and any.
- RR mode instantiates lsb_find twice:
  - once on req & ~((1<<ptr)-1), the masked upper part;
  - once on raw req.
- The masked result wins if its any=1; otherwise the raw result is used.
- Fixed mode uses one instance.
- The top level contains the handshake register, ptr and the result muxing.

## Test plan
- Fixed, WIDTH=8:
  - req=8'b0001_0100 accepted → next cycle pos=2, grant=8'h04, none=0, out_valid=1.
  - req=8'h00 → pos=0, grant=0, none=1.
- RR, WIDTH=8: accept 8'hFF four times back-to-back with out_ready=1 → pos sequence 0,1,2,3; ptr=4 afterwards.
- RR wrap, WIDTH=8:
  - with ptr=6, req=8'b0000_0011 → pos=0, ptr→1;
  - then req=8'b1000_0001 → pos=7, ptr→0.
- RR, non-power-of-two WIDTH=5: req=5'b10000 with ptr=4 → pos=4, ptr→0 (never 5).
- Backpressure:
  - hold out_ready=0 with out_valid=1 → in_ready=0; a changing req does not alter pos; ptr is frozen.
  - raise out_ready → the same cycle drains and accepts, and out_valid stays 1.
- Async reset: assert resetn=0 mid-stream between clock edges → out_valid=0, grant=0 immediately. After release, req=8'h80 in RR mode → pos=7.
